// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and its datapath. The controller
// receives the IR fields and status flags and drives every enable and select.
interface multicycle_controller_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       memready;

  logic       iord;
  logic       memwrite;
  logic       irwrite;
  logic       pcen;
  logic [1:0] pcsrc;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [2:0] alucontrol;
  logic [1:0] shift;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic       link;
  logic       retire;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  op, funct, zero, memready,
    output iord, memwrite, irwrite, pcen, pcsrc, alusrca, alusrcb, alucontrol,
           shift, regdst, memtoreg, regwrite, link, retire, illegal, state
  );

  modport slave (
    output op, funct, zero, memready,
    input  iord, memwrite, irwrite, pcen, pcsrc, alusrca, alusrcb, alucontrol,
           shift, regdst, memtoreg, regwrite, link, retire, illegal, state
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM: sequences a shared-memory datapath through
// fetch/decode/execute/memory/writeback states with a memready stall handshake.
module multicycle_controller (
  input  logic                   clk,
  input  logic                   reset,
  multicycle_controller_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_IEXEC   = 4'd9,
    S_IWB     = 4'd10,
    S_JUMP    = 4'd11,
    S_JAL     = 4'd12,
    S_JR      = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SRA = 6'b000011;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // fetch/retire_rdy mark the memory states whose strobes wait on memready.
  typedef struct packed {
    logic       iord;
    logic       memwrite;
    logic       fetch;
    logic       pcwrite;
    logic       branch;
    logic [1:0] pcsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [2:0] alucontrol;
    logic [1:0] shift;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       link;
    logic       retire;
    logic       retire_rdy;
  } ctrl_t;

  function automatic ctrl_t moore_ctrl(input state_t s, input logic [5:0] op,
                                       input logic [5:0] funct);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.fetch      = 1'b1;
        c.alusrcb    = 2'b01;
        c.alucontrol = ALU_ADD;
      end
      S_DECODE: begin
        c.alusrcb    = 2'b11;
        c.alucontrol = ALU_ADD;
      end
      S_MEMADR: begin
        c.alusrca    = 1'b1;
        c.alusrcb    = 2'b10;
        c.alucontrol = ALU_ADD;
      end
      S_MEMRD: c.iord = 1'b1;
      S_MEMWB: begin
        c.memtoreg = 1'b1;
        c.regwrite = 1'b1;
        c.retire   = 1'b1;
      end
      S_MEMWR: begin
        c.iord       = 1'b1;
        c.memwrite   = 1'b1;
        c.retire_rdy = 1'b1;
      end
      S_EXECUTE: begin
        c.alusrca = 1'b1;
        case (funct)
          FN_SUB:  c.alucontrol = ALU_SUB;
          FN_AND:  c.alucontrol = ALU_AND;
          FN_OR:   c.alucontrol = ALU_OR;
          FN_SLT:  c.alucontrol = ALU_SLT;
          default: c.alucontrol = ALU_ADD;
        endcase
        case (funct)
          FN_SLL:  c.shift = 2'b01;
          FN_SRL:  c.shift = 2'b10;
          FN_SRA:  c.shift = 2'b11;
          default: c.shift = 2'b00;
        endcase
      end
      S_ALUWB: begin
        c.regdst   = 1'b1;
        c.regwrite = 1'b1;
        c.retire   = 1'b1;
      end
      S_BRANCH: begin
        c.alusrca    = 1'b1;
        c.alucontrol = ALU_SUB;
        c.branch     = 1'b1;
        c.pcsrc      = 2'b01;
        c.retire     = 1'b1;
      end
      S_IEXEC: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
        case (op)
          OP_ANDI: c.alucontrol = ALU_AND;
          OP_ORI:  c.alucontrol = ALU_OR;
          OP_SLTI: c.alucontrol = ALU_SLT;
          default: c.alucontrol = ALU_ADD;
        endcase
      end
      S_IWB: begin
        c.regwrite = 1'b1;
        c.retire   = 1'b1;
      end
      S_JUMP: begin
        c.pcsrc   = 2'b10;
        c.pcwrite = 1'b1;
        c.retire  = 1'b1;
      end
      S_JAL: begin
        c.pcsrc    = 2'b10;
        c.pcwrite  = 1'b1;
        c.regwrite = 1'b1;
        c.link     = 1'b1;
        c.retire   = 1'b1;
      end
      S_JR: begin
        c.pcsrc   = 2'b11;
        c.pcwrite = 1'b1;
        c.retire  = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_t state_q;
  state_t state_next;
  ctrl_t  ctrl_q;
  ctrl_t  fetch_ctrl;
  ctrl_t  c;
  logic   legal;
  logic   pcwrite;

  assign fetch_ctrl = moore_ctrl(S_FETCH, 6'd0, 6'd0);

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_next = S_FETCH;
    legal      = 1'b1;
    case (state_q)
      S_FETCH:  state_next = bus.memready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW:                      state_next = S_MEMADR;
          OP_BEQ, OP_BNE:                    state_next = S_BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_next = S_IEXEC;
          OP_J:                              state_next = S_JUMP;
          OP_JAL:                            state_next = S_JAL;
          OP_RTYPE: begin
            case (bus.funct)
              FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT,
              FN_SLL, FN_SRL, FN_SRA:        state_next = S_EXECUTE;
              FN_JR:                         state_next = S_JR;
              default:                       legal = 1'b0;
            endcase
          end
          default:                           legal = 1'b0;
        endcase
      end
      S_MEMADR:  state_next = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_next = bus.memready ? S_MEMWB : S_MEMRD;
      S_MEMWR:   state_next = bus.memready ? S_FETCH : S_MEMWR;
      S_EXECUTE: state_next = S_ALUWB;
      S_IEXEC:   state_next = S_IWB;
      default:   state_next = S_FETCH;
    endcase
  end

  // Moore outputs are registered alongside the state, decoded from the state being entered;
  // op/funct are stable then because IR only loads on the FETCH->DECODE edge.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_FETCH;
      ctrl_q  <= fetch_ctrl;
    end else begin
      state_q <= state_next;
      ctrl_q  <= moore_ctrl(state_next, bus.op, bus.funct);
    end
  end

  // While reset is held, present FETCH selects and suppress every side-effecting strobe.
  assign c       = reset ? ctrl_q : fetch_ctrl;
  assign pcwrite = c.pcwrite | (c.fetch & bus.memready);

  assign bus.iord       = c.iord;
  assign bus.memwrite   = reset & c.memwrite;
  assign bus.irwrite    = reset & c.fetch & bus.memready;
  assign bus.pcen       = reset & (pcwrite | (c.branch & (bus.op[0] ^ bus.zero)));
  assign bus.pcsrc      = c.pcsrc;
  assign bus.alusrca    = c.alusrca;
  assign bus.alusrcb    = c.alusrcb;
  assign bus.alucontrol = c.alucontrol;
  assign bus.shift      = c.shift;
  assign bus.regdst     = c.regdst;
  assign bus.memtoreg   = c.memtoreg;
  assign bus.regwrite   = reset & c.regwrite;
  assign bus.link       = c.link;
  assign bus.retire     = reset & (c.retire | (c.retire_rdy & bus.memready));
  assign bus.illegal    = reset & (state_q == S_DECODE) & ~legal;
  assign bus.state      = state_q;

endmodule
